// File: rtl/sa_write_channel.sv
// Write-channel arbiter: merges per-master AW/W streams onto one slave port and routes B back by ID.
// Define SA_WR_FIXED_PRIO_EN for fixed-priority AW arbitration (lowest index wins) instead of round-robin.
module sa_write_channel #(
  parameter int MST_AMT           = 2,
  parameter int OUTSTANDING_AMT   = 8,
  parameter int DATA_WIDTH        = 32,
  parameter int ADDR_WIDTH        = 32,
  parameter int TRANS_MST_ID_W    = 5,
  parameter int TRANS_BURST_W     = 2,
  parameter int TRANS_DATA_LEN_W  = 3,
  parameter int TRANS_DATA_SIZE_W = 3,
  parameter int TRANS_WR_RESP_W   = 2,
  localparam int MST_ID_W         = $clog2(MST_AMT)
) (
  input  logic                                   ACLK_i,
  input  logic                                   ARESETn_i,
  input  logic [TRANS_MST_ID_W*MST_AMT-1:0]      dsp_AWID_i,
  input  logic [ADDR_WIDTH*MST_AMT-1:0]          dsp_AWADDR_i,
  input  logic [TRANS_BURST_W*MST_AMT-1:0]       dsp_AWBURST_i,
  input  logic [TRANS_DATA_LEN_W*MST_AMT-1:0]    dsp_AWLEN_i,
  input  logic [TRANS_DATA_SIZE_W*MST_AMT-1:0]   dsp_AWSIZE_i,
  input  logic [MST_AMT-1:0]                     dsp_AWVALID_i,
  input  logic [DATA_WIDTH*MST_AMT-1:0]          dsp_WDATA_i,
  input  logic [MST_AMT-1:0]                     dsp_WLAST_i,
  input  logic [MST_AMT-1:0]                     dsp_WVALID_i,
  input  logic [MST_AMT-1:0]                     dsp_BREADY_i,
  output logic [MST_AMT-1:0]                     dsp_AWREADY_o,
  output logic [MST_AMT-1:0]                     dsp_WREADY_o,
  output logic [MST_AMT-1:0]                     dsp_BVALID_o,
  output logic [TRANS_MST_ID_W-1:0]              dsp_BID_o,
  output logic [TRANS_WR_RESP_W-1:0]             dsp_BRESP_o,
  output logic [TRANS_MST_ID_W+MST_ID_W-1:0]     s_AWID_o,
  output logic [ADDR_WIDTH-1:0]                  s_AWADDR_o,
  output logic [TRANS_BURST_W-1:0]               s_AWBURST_o,
  output logic [TRANS_DATA_LEN_W-1:0]            s_AWLEN_o,
  output logic [TRANS_DATA_SIZE_W-1:0]           s_AWSIZE_o,
  output logic                                   s_AWVALID_o,
  input  logic                                   s_AWREADY_i,
  output logic [DATA_WIDTH-1:0]                  s_WDATA_o,
  output logic                                   s_WLAST_o,
  output logic                                   s_WVALID_o,
  input  logic                                   s_WREADY_i,
  input  logic [TRANS_MST_ID_W+MST_ID_W-1:0]     s_BID_i,
  input  logic [TRANS_WR_RESP_W-1:0]             s_BRESP_i,
  input  logic                                   s_BVALID_i,
  output logic                                   s_BREADY_o
);

  localparam int PTR_W = $clog2(OUTSTANDING_AMT);
  localparam int CNT_W = $clog2(OUTSTANDING_AMT + 1);

  // Handshakes: a beat transfers on a rising edge where valid and ready are both high;
  // valid never waits on ready, and a raised valid holds its payload until that transfer.

  logic                         grant_any;
  logic [MST_ID_W-1:0]          grant_idx;
  logic                         aw_free;
  logic                         aw_grant;
  logic [TRANS_MST_ID_W-1:0]    sel_id;
  logic [ADDR_WIDTH-1:0]        sel_addr;
  logic [TRANS_BURST_W-1:0]     sel_burst;
  logic [TRANS_DATA_LEN_W-1:0]  sel_len;
  logic [TRANS_DATA_SIZE_W-1:0] sel_size;

  logic [MST_ID_W-1:0] fifo_mem [OUTSTANDING_AMT];
  logic [PTR_W-1:0]    wr_ptr, rd_ptr;
  logic [CNT_W-1:0]    fifo_cnt;
  logic                fifo_full, fifo_empty;
  logic                push, pop;
  logic [MST_ID_W-1:0] head;
  logic [MST_ID_W-1:0] b_mst;

`ifndef SA_WR_FIXED_PRIO_EN
  logic [MST_ID_W-1:0] rr_ptr;
`endif

  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
`ifndef SA_WR_FIXED_PRIO_EN
    // First pass covers masters at or above the pointer, second pass wraps around.
    for (int j = 0; j < MST_AMT; j++) begin
      if (!grant_any && dsp_AWVALID_i[j] && (MST_ID_W'(j) >= rr_ptr)) begin
        grant_any = 1'b1;
        grant_idx = MST_ID_W'(j);
      end
    end
`endif
    for (int j = 0; j < MST_AMT; j++) begin
      if (!grant_any && dsp_AWVALID_i[j]) begin
        grant_any = 1'b1;
        grant_idx = MST_ID_W'(j);
      end
    end
  end

  assign aw_free  = !s_AWVALID_o || s_AWREADY_i;
  assign aw_grant = ARESETn_i && grant_any && aw_free && !fifo_full;

  always_comb begin
    dsp_AWREADY_o = '0;
    sel_id        = '0;
    sel_addr      = '0;
    sel_burst     = '0;
    sel_len       = '0;
    sel_size      = '0;
    for (int j = 0; j < MST_AMT; j++) begin
      if (grant_idx == MST_ID_W'(j)) begin
        dsp_AWREADY_o[j] = aw_grant;
        sel_id    = dsp_AWID_i[j*TRANS_MST_ID_W +: TRANS_MST_ID_W];
        sel_addr  = dsp_AWADDR_i[j*ADDR_WIDTH +: ADDR_WIDTH];
        sel_burst = dsp_AWBURST_i[j*TRANS_BURST_W +: TRANS_BURST_W];
        sel_len   = dsp_AWLEN_i[j*TRANS_DATA_LEN_W +: TRANS_DATA_LEN_W];
        sel_size  = dsp_AWSIZE_i[j*TRANS_DATA_SIZE_W +: TRANS_DATA_SIZE_W];
      end
    end
  end

  always_ff @(posedge ACLK_i or negedge ARESETn_i) begin
    if (!ARESETn_i) begin
      s_AWVALID_o <= 1'b0;
      s_AWID_o    <= '0;
      s_AWADDR_o  <= '0;
      s_AWBURST_o <= '0;
      s_AWLEN_o   <= '0;
      s_AWSIZE_o  <= '0;
    end else if (aw_grant) begin
      s_AWVALID_o <= 1'b1;
      s_AWID_o    <= {grant_idx, sel_id};
      s_AWADDR_o  <= sel_addr;
      s_AWBURST_o <= sel_burst;
      s_AWLEN_o   <= sel_len;
      s_AWSIZE_o  <= sel_size;
    end else if (s_AWREADY_i) begin
      s_AWVALID_o <= 1'b0;
    end
  end

`ifndef SA_WR_FIXED_PRIO_EN
  always_ff @(posedge ACLK_i or negedge ARESETn_i) begin
    if (!ARESETn_i) begin
      rr_ptr <= '0;
    end else if (aw_grant) begin
      rr_ptr <= (grant_idx == MST_ID_W'(MST_AMT - 1)) ? '0 : grant_idx + 1'b1;
    end
  end
`endif

  // W-order FIFO: records which master owns each accepted AW so its W beats follow in order.
  assign fifo_full  = (fifo_cnt == CNT_W'(OUTSTANDING_AMT));
  assign fifo_empty = (fifo_cnt == '0);
  assign push       = aw_grant;
  assign pop        = s_WVALID_o && s_WREADY_i && s_WLAST_o;
  assign head       = fifo_mem[rd_ptr];

  always_ff @(posedge ACLK_i) begin
    if (push) fifo_mem[wr_ptr] <= grant_idx;
  end

  always_ff @(posedge ACLK_i or negedge ARESETn_i) begin
    if (!ARESETn_i) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == PTR_W'(OUTSTANDING_AMT - 1)) ? '0 : wr_ptr + 1'b1;
      if (pop)  rd_ptr <= (rd_ptr == PTR_W'(OUTSTANDING_AMT - 1)) ? '0 : rd_ptr + 1'b1;
      if (push && !pop)      fifo_cnt <= fifo_cnt + 1'b1;
      else if (pop && !push) fifo_cnt <= fifo_cnt - 1'b1;
    end
  end

  always_comb begin
    s_WDATA_o    = '0;
    s_WLAST_o    = 1'b0;
    s_WVALID_o   = 1'b0;
    dsp_WREADY_o = '0;
    for (int j = 0; j < MST_AMT; j++) begin
      if (!fifo_empty && (head == MST_ID_W'(j))) begin
        s_WDATA_o       = dsp_WDATA_i[j*DATA_WIDTH +: DATA_WIDTH];
        s_WLAST_o       = dsp_WLAST_i[j];
        s_WVALID_o      = dsp_WVALID_i[j];
        dsp_WREADY_o[j] = s_WREADY_i;
      end
    end
  end

  // Responses for an out-of-range master index fall through the loop and are sunk.
  assign b_mst       = s_BID_i[TRANS_MST_ID_W +: MST_ID_W];
  assign dsp_BID_o   = s_BID_i[TRANS_MST_ID_W-1:0];
  assign dsp_BRESP_o = s_BRESP_i;

  always_comb begin
    dsp_BVALID_o = '0;
    s_BREADY_o   = 1'b1;
    for (int j = 0; j < MST_AMT; j++) begin
      if (b_mst == MST_ID_W'(j)) begin
        dsp_BVALID_o[j] = s_BVALID_i;
        s_BREADY_o      = dsp_BREADY_i[j];
      end
    end
  end

endmodule

// File: tb/tb_sa_write_channel.sv
// Directed bench for sa_write_channel: AW/W ordering scoreboard plus B routing and reset checks.
module tb_sa_write_channel;

  logic        ACLK_i;
  logic        ARESETn_i;
  logic [9:0]  dsp_AWID_i;
  logic [63:0] dsp_AWADDR_i;
  logic [3:0]  dsp_AWBURST_i;
  logic [5:0]  dsp_AWLEN_i;
  logic [5:0]  dsp_AWSIZE_i;
  logic [1:0]  dsp_AWVALID_i;
  logic [63:0] dsp_WDATA_i;
  logic [1:0]  dsp_WLAST_i;
  logic [1:0]  dsp_WVALID_i;
  logic [1:0]  dsp_BREADY_i;
  logic [1:0]  dsp_AWREADY_o;
  logic [1:0]  dsp_WREADY_o;
  logic [1:0]  dsp_BVALID_o;
  logic [4:0]  dsp_BID_o;
  logic [1:0]  dsp_BRESP_o;
  logic [5:0]  s_AWID_o;
  logic [31:0] s_AWADDR_o;
  logic [1:0]  s_AWBURST_o;
  logic [2:0]  s_AWLEN_o;
  logic [2:0]  s_AWSIZE_o;
  logic        s_AWVALID_o;
  logic        s_AWREADY_i;
  logic [31:0] s_WDATA_o;
  logic        s_WLAST_o;
  logic        s_WVALID_o;
  logic        s_WREADY_i;
  logic [5:0]  s_BID_i;
  logic [1:0]  s_BRESP_i;
  logic        s_BVALID_i;
  logic        s_BREADY_o;

  int checks = 0;
  int errors = 0;
  logic [37:0] aw_q[$];
  logic [31:0] w_q[$];

  sa_write_channel dut (
    .ACLK_i(ACLK_i), .ARESETn_i(ARESETn_i),
    .dsp_AWID_i(dsp_AWID_i), .dsp_AWADDR_i(dsp_AWADDR_i), .dsp_AWBURST_i(dsp_AWBURST_i),
    .dsp_AWLEN_i(dsp_AWLEN_i), .dsp_AWSIZE_i(dsp_AWSIZE_i), .dsp_AWVALID_i(dsp_AWVALID_i),
    .dsp_WDATA_i(dsp_WDATA_i), .dsp_WLAST_i(dsp_WLAST_i), .dsp_WVALID_i(dsp_WVALID_i),
    .dsp_BREADY_i(dsp_BREADY_i), .dsp_AWREADY_o(dsp_AWREADY_o), .dsp_WREADY_o(dsp_WREADY_o),
    .dsp_BVALID_o(dsp_BVALID_o), .dsp_BID_o(dsp_BID_o), .dsp_BRESP_o(dsp_BRESP_o),
    .s_AWID_o(s_AWID_o), .s_AWADDR_o(s_AWADDR_o), .s_AWBURST_o(s_AWBURST_o),
    .s_AWLEN_o(s_AWLEN_o), .s_AWSIZE_o(s_AWSIZE_o), .s_AWVALID_o(s_AWVALID_o),
    .s_AWREADY_i(s_AWREADY_i), .s_WDATA_o(s_WDATA_o), .s_WLAST_o(s_WLAST_o),
    .s_WVALID_o(s_WVALID_o), .s_WREADY_i(s_WREADY_i), .s_BID_i(s_BID_i),
    .s_BRESP_i(s_BRESP_i), .s_BVALID_i(s_BVALID_i), .s_BREADY_o(s_BREADY_o)
  );

  // Clock and reset
  initial ACLK_i = 1'b0;
  always #5 ACLK_i = ~ACLK_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [37:0] aw_exp(input logic m, input logic [4:0] id, input logic [31:0] a);
    return {m, id, a};
  endfunction

  // Scoreboard: pop an expected AW / W beat for every slave-side handshake.
  task automatic sb_sample();
    logic [37:0] ea;
    logic [31:0] ew;
    if (ARESETn_i && s_AWVALID_o && s_AWREADY_i) begin
      if (aw_q.size() == 0) chk("aw_unexpected", 64'd1, 64'd0);
      else begin
        ea = aw_q.pop_front();
        chk("aw_beat", {s_AWID_o, s_AWADDR_o}, ea);
      end
    end
    if (ARESETn_i && s_WVALID_o && s_WREADY_i) begin
      if (w_q.size() == 0) chk("w_unexpected", 64'd1, 64'd0);
      else begin
        ew = w_q.pop_front();
        chk("w_beat", s_WDATA_o, ew);
      end
    end
  endtask

  // Inputs change 1 time unit after a rising edge; checks run on the falling edge.
  task automatic mid();
    @(negedge ACLK_i);
    sb_sample();
  endtask

  task automatic next_edge();
    @(posedge ACLK_i);
    #1;
  endtask

  initial begin
    ARESETn_i = 1'b0;
    dsp_AWID_i = '0; dsp_AWADDR_i = '0; dsp_AWBURST_i = 4'b0101; dsp_AWLEN_i = '0;
    dsp_AWSIZE_i = {3'd2, 3'd2}; dsp_AWVALID_i = '0; dsp_WDATA_i = '0; dsp_WLAST_i = '0;
    dsp_WVALID_i = '0; dsp_BREADY_i = '0; s_AWREADY_i = 1'b0; s_WREADY_i = 1'b0;
    s_BID_i = '0; s_BRESP_i = '0; s_BVALID_i = 1'b0;

    // Reset state, with requests pending to show AWREADY is held off
    repeat (2) @(posedge ACLK_i);
    #1;
    dsp_AWVALID_i = 2'b11;
    mid();
    chk("rst_awvalid", s_AWVALID_o, 0);
    chk("rst_wvalid", s_WVALID_o, 0);
    chk("rst_awready", dsp_AWREADY_o, 0);
    chk("rst_wready", dsp_WREADY_o, 0);
    chk("rst_awid", s_AWID_o, 0);
    next_edge();

    // Simultaneous requests: master 0 then master 1
    ARESETn_i = 1'b1;
    s_AWREADY_i = 1'b1;
    dsp_AWID_i = {5'h11, 5'h03};
    dsp_AWADDR_i = {32'hA100_0010, 32'hA000_0000};
    aw_q.push_back(aw_exp(1'b0, 5'h03, 32'hA000_0000));
    mid();
    chk("rr_first", dsp_AWREADY_o, 2'b01);
    next_edge();
    dsp_AWVALID_i = 2'b10;
    aw_q.push_back(aw_exp(1'b1, 5'h11, 32'hA100_0010));
    mid();
    chk("rr_second", dsp_AWREADY_o, 2'b10);
    next_edge();
    dsp_AWVALID_i = 2'b00;
    mid();
    chk("aw_idle", dsp_AWREADY_o, 2'b00);
    next_edge();

    // W ordering: master 0 two beats, then master 1 four beats
    s_WREADY_i = 1'b1;
    dsp_WVALID_i = 2'b11;
    dsp_WDATA_i = {32'hE000_0000, 32'hD000_0000};
    dsp_WLAST_i = 2'b00;
    w_q.push_back(32'hD000_0000);
    mid();
    chk("w_m0_beat0_ready", dsp_WREADY_o, 2'b01);
    next_edge();
    dsp_WDATA_i = {32'hE000_0000, 32'hD000_0001};
    dsp_WLAST_i = 2'b01;
    w_q.push_back(32'hD000_0001);
    mid();
    chk("w_m0_beat1_ready", dsp_WREADY_o, 2'b01);
    chk("w_m0_last", s_WLAST_o, 1);
    next_edge();
    for (int k = 0; k < 4; k++) begin
      dsp_WVALID_i = 2'b10;
      dsp_WDATA_i = {32'hE000_0000 + 32'(k), 32'h0};
      dsp_WLAST_i = {(k == 3), 1'b0};
      w_q.push_back(32'hE000_0000 + 32'(k));
      mid();
      chk("w_m1_ready", dsp_WREADY_o, 2'b10);
      next_edge();
    end
    dsp_WVALID_i = 2'b01;
    dsp_WLAST_i = 2'b01;
    mid();
    chk("w_empty_stall", s_WVALID_o, 0);
    chk("w_empty_ready", dsp_WREADY_o, 2'b00);
    next_edge();

    // Fill the W-order FIFO while the slave W channel is stalled
    dsp_WVALID_i = 2'b00;
    s_WREADY_i = 1'b0;
    dsp_AWVALID_i = 2'b01;
    for (int i = 0; i < 8; i++) begin
      dsp_AWID_i[4:0] = 5'(i);
      dsp_AWADDR_i[31:0] = 32'hB000_0000 + 32'(i);
      aw_q.push_back(aw_exp(1'b0, 5'(i), 32'hB000_0000 + 32'(i)));
      mid();
      chk("fill_grant", dsp_AWREADY_o, 2'b01);
      next_edge();
    end
    for (int i = 0; i < 3; i++) begin
      mid();
      chk("full_block", dsp_AWREADY_o, 2'b00);
      next_edge();
    end
    dsp_WVALID_i = 2'b01;
    dsp_WLAST_i = 2'b01;
    dsp_WDATA_i[31:0] = 32'hC000_0000;
    s_WREADY_i = 1'b1;
    w_q.push_back(32'hC000_0000);
    mid();
    chk("full_pop_same_cycle", dsp_AWREADY_o, 2'b00);
    next_edge();
    dsp_WVALID_i = 2'b00;
    s_WREADY_i = 1'b0;
    dsp_AWID_i[4:0] = 5'h1F;
    dsp_AWADDR_i[31:0] = 32'hB000_00FF;
    aw_q.push_back(aw_exp(1'b0, 5'h1F, 32'hB000_00FF));
    mid();
    chk("after_pop_grant", dsp_AWREADY_o, 2'b01);
    next_edge();

    // Drain six entries, leaving two outstanding
    dsp_AWVALID_i = 2'b00;
    dsp_WVALID_i = 2'b01;
    s_WREADY_i = 1'b1;
    for (int k = 0; k < 6; k++) begin
      dsp_WDATA_i[31:0] = 32'hC000_0010 + 32'(k);
      w_q.push_back(32'hC000_0010 + 32'(k));
      mid();
      next_edge();
    end
    dsp_WVALID_i = 2'b00;
    s_WREADY_i = 1'b0;

    // One more AW with the slave not ready: three outstanding, AW held
    s_AWREADY_i = 1'b0;
    dsp_AWVALID_i = 2'b01;
    dsp_AWID_i[4:0] = 5'h0A;
    dsp_AWADDR_i[31:0] = 32'hD000_0000;
    mid();
    chk("hold_grant", dsp_AWREADY_o, 2'b01);
    next_edge();
    dsp_AWVALID_i = 2'b11;
    mid();
    chk("hold_valid", s_AWVALID_o, 1);
    chk("hold_id", s_AWID_o, 6'h0A);
    chk("hold_addr", s_AWADDR_o, 32'hD000_0000);
    chk("hold_blocks_grant", dsp_AWREADY_o, 2'b00);
    next_edge();

    // Reset mid-operation
    ARESETn_i = 1'b0;
    dsp_WVALID_i = 2'b01;
    dsp_WLAST_i = 2'b01;
    s_WREADY_i = 1'b1;
    mid();
    chk("midrst_awvalid", s_AWVALID_o, 0);
    chk("midrst_wvalid", s_WVALID_o, 0);
    chk("midrst_awready", dsp_AWREADY_o, 2'b00);
    chk("midrst_wready", dsp_WREADY_o, 2'b00);
    chk("midrst_awaddr", s_AWADDR_o, 0);
    next_edge();
    ARESETn_i = 1'b1;
    s_AWREADY_i = 1'b1;
    dsp_AWID_i = {5'h15, 5'h06};
    dsp_AWADDR_i = {32'hE200_0000, 32'hE100_0000};
    aw_q.push_back(aw_exp(1'b0, 5'h06, 32'hE100_0000));
    mid();
    chk("post_rst_awvalid", s_AWVALID_o, 0);
    chk("post_rst_wvalid", s_WVALID_o, 0);
    chk("post_rst_wready", dsp_WREADY_o, 2'b00);
    chk("post_rst_ptr", dsp_AWREADY_o, 2'b01);
    next_edge();
    dsp_AWVALID_i = 2'b00;
    dsp_WVALID_i = 2'b00;
    mid();
    next_edge();

    // B routing
    s_BID_i = {1'b1, 5'd7};
    s_BVALID_i = 1'b1;
    s_BRESP_i = 2'b10;
    dsp_BREADY_i = 2'b00;
    mid();
    chk("b_valid_m1", dsp_BVALID_o, 2'b10);
    chk("b_id_m1", dsp_BID_o, 5'd7);
    chk("b_resp", dsp_BRESP_o, 2'b10);
    chk("b_ready_low", s_BREADY_o, 0);
    next_edge();
    dsp_BREADY_i = 2'b10;
    mid();
    chk("b_valid_m1_hold", dsp_BVALID_o, 2'b10);
    chk("b_id_m1_hold", dsp_BID_o, 5'd7);
    chk("b_ready_high", s_BREADY_o, 1);
    next_edge();
    s_BID_i = {1'b0, 5'd3};
    s_BRESP_i = 2'b01;
    dsp_BREADY_i = 2'b10;
    mid();
    chk("b_valid_m0", dsp_BVALID_o, 2'b01);
    chk("b_id_m0", dsp_BID_o, 5'd3);
    chk("b_ready_m0_low", s_BREADY_o, 0);
    next_edge();
    s_BVALID_i = 1'b0;

    // Final report
    chk("aw_q_drained", aw_q.size(), 0);
    chk("w_q_drained", w_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sa_write_channel.md
SA_WRITE_CHANNEL -- requirements
Module: sa_write_channel

Interface
REQ-001 SHALL have parameter MST_AMT, default 2: number of master dispatchers, at least 2; localparam MST_ID_W = $clog2(MST_AMT).
REQ-002 SHALL have parameter OUTSTANDING_AMT, default 8: W-order FIFO depth.
REQ-003 SHALL have parameters DATA_WIDTH 32, ADDR_WIDTH 32, TRANS_MST_ID_W 5, TRANS_BURST_W 2, TRANS_DATA_LEN_W 3, TRANS_DATA_SIZE_W 3, TRANS_WR_RESP_W 2, with the same meanings as in the dispatcher.
REQ-004 SHALL have one clock and an asynchronous active-low reset: ACLK_i and ARESETn_i.
REQ-005 Master-side input buses, all packed per master:
- dsp_AWID_i, dsp_AWADDR_i, dsp_AWBURST_i, dsp_AWLEN_i, dsp_AWSIZE_i: input, xW*MST_AMT, AW payload.
- dsp_AWVALID_i: input, MST_AMT, AW valid.
- dsp_WDATA_i: input, DATA_WIDTH*MST_AMT, write data.
- dsp_WLAST_i, dsp_WVALID_i: input, MST_AMT, W control.
- dsp_BREADY_i: input, MST_AMT, B ready.
REQ-006 Master-side outputs:
- dsp_AWREADY_o, dsp_WREADY_o, dsp_BVALID_o: output, MST_AMT.
- dsp_BID_o: output, TRANS_MST_ID_W; broadcast to all masters.
- dsp_BRESP_o: output, TRANS_WR_RESP_W; broadcast to all masters.
REQ-007 Slave-side ports:
- s_AWID_o: output, TRANS_MST_ID_W+MST_ID_W.
- s_AWADDR_o, s_AWBURST_o, s_AWLEN_o, s_AWSIZE_o, s_AWVALID_o: outputs.
- s_AWREADY_i: input, 1.
- s_WDATA_o, s_WLAST_o, s_WVALID_o: outputs.
- s_WREADY_i: input, 1.
- s_BID_i: input, TRANS_MST_ID_W+MST_ID_W.
- s_BRESP_i, s_BVALID_i: inputs.
- s_BREADY_o: output, 1.

Function
REQ-008 SHALL treat the AW output register as free when s_AWVALID_o=0, or when s_AWVALID_o and s_AWREADY_i are both high in the same cycle.
REQ-009 SHALL grant AW only when the AW output register is free and the W-order FIFO is not full; the grant goes to one requesting master g, chosen round-robin starting at the pointer.
REQ-010 SHALL drive dsp_AWREADY_o[g]=1 combinationally in the grant cycle and keep all other AWREADY bits at 0.
REQ-011 SHALL, on a grant, register the payload of master g and assert s_AWVALID_o on the next edge (latency 1).
REQ-012 SHALL hold s_AWVALID_o and the payload stable until s_AWREADY_i; the register supports back-to-back grants, one per cycle.
REQ-013 SHALL drive s_AWID_o = {g, dsp_AWID_i[g]}.
REQ-014 SHALL, on a grant, push g into the W-order FIFO and set the round-robin pointer to (g+1) mod MST_AMT.
REQ-015 SHALL, while the FIFO is non-empty with head h:
- route dsp_W*[h] combinationally to s_W*;
- drive dsp_WREADY_o[h]=s_WREADY_i and all other WREADY bits to 0.
REQ-016 SHALL, while the FIFO is empty, drive s_WVALID_o=0 and all dsp_WREADY_o bits to 0; W beats that arrive before their AW stall.
REQ-017 SHALL pop the FIFO on a beat where s_WVALID_o, s_WREADY_i and s_WLAST_o are all high.
REQ-018 SHALL allow a push and a pop in the same cycle; the count is unchanged. Push is blocked when the FIFO is full, even if a pop occurs in that cycle.
REQ-019 SHALL decode m = s_BID_i[MSB:TRANS_MST_ID_W] and drive:
- dsp_BVALID_o[m]=s_BVALID_i;
- s_BREADY_o=dsp_BREADY_i[m];
- dsp_BID_o = s_BID_i low bits;
- dsp_BRESP_o = s_BRESP_i.
REQ-020 SHALL, for m >= MST_AMT, drive s_BREADY_o=1 and all dsp_BVALID_o bits to 0, so the response is sunk.

Reset
REQ-021 On ARESETn_i low, asynchronously:
- s_AWVALID_o=0 and AW payload register = 0;
- FIFO empty;
- round-robin pointer = 0.
Consequently s_WVALID_o=0 and all dsp_AWREADY_o and dsp_WREADY_o bits are 0.
REQ-022 SHALL discard any in-flight AW or W transaction when reset is asserted mid-operation; no pending AW is re-issued after reset release.

Configuration
REQ-023 With SA_WR_FIXED_PRIO_EN defined, SHALL grant AW by fixed priority (lowest index wins) and SHALL contain no pointer register. Without it, SHALL use round-robin per REQ-009/REQ-014.

Verification
REQ-024 Masters 0 and 1 assert AWVALID in the same cycle, pointer=0:
- master 0 is granted first, master 1 next;
- s_AWID_o is {0,ID0}, then {1,ID1}.
REQ-025 Master 1 sends a 4-beat burst after master 0 sends a 2-beat burst:
- s_W carries master 0's 2 beats, then master 1's 4 beats;
- master 1 WREADY stays 0 during master 0's beats.
REQ-026 With s_WREADY_i=0, 8 AWs are granted: the 9th AWREADY stays 0 until the first WLAST handshake.
REQ-027 s_BID_i={1,5'd7}, BVALID=1, dsp_BREADY_i=2'b00, then 2'b10:
- dsp_BVALID_o=2'b10 and dsp_BID_o=7 throughout;
- s_BREADY_o goes 0, then 1.
REQ-028 Reset asserted with s_AWVALID_o=1 and FIFO count 3: all valids are 0 the same cycle; after release the FIFO is empty.
